// File: rtl/noc_traffic_pkg.sv
// Shared types and default widths for the NoC random traffic injector.
package noc_traffic_pkg;

  localparam int unsigned RAND_W_DEF = 9;
  localparam int unsigned DEST_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SEQ_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lfsr_step.sv
// Stepping LFSR: shift left, feedback = msb ^ lsb into bit 0; load wins over step.
module lfsr_step
  import noc_traffic_pkg::*;
#(
  parameter int unsigned         RAND_W = RAND_W_DEF,
  parameter logic [RAND_W-1:0]   SEED   = RAND_W'(1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              I_EN,
  input  logic              I_LOAD,
  output logic [RAND_W-1:0] O_DATA
);

  // LFSR register: seed on reset or load, one step when enabled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      O_DATA <= SEED;
    end else if (I_LOAD) begin
      O_DATA <= SEED;
    end else if (I_EN) begin
      O_DATA <= {O_DATA[RAND_W-2:0], O_DATA[RAND_W-1] ^ O_DATA[0]};
    end
  end

endmodule

// File: rtl/rand_traffic_ctrl.sv
// Random traffic-injection controller: LFSR-driven packet generator with valid/ready output.
module rand_traffic_ctrl
  import noc_traffic_pkg::*;
#(
  parameter int unsigned       RAND_W = RAND_W_DEF,
  parameter logic [RAND_W-1:0] SEED   = RAND_W'(1),
  parameter int unsigned       DEST_W = DEST_W_DEF,
  parameter int unsigned       DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              I_START,
  input  logic              I_STOP,
  input  logic [SEQ_W-1:0]  I_PKT_NUM,
  input  logic [7:0]        I_RATE,
  input  logic [DEST_W-1:0] I_SRC_ID,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DEST_W-1:0] O_DEST,
  output logic [DATA_W-1:0] O_DATA,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [SEQ_W-1:0]  O_SENT_CNT
);

  state_t             state;
  logic [SEQ_W-1:0]   pkt_num;
  logic               stop_pend;
  logic [RAND_W-1:0]  rnd;
  logic               lfsr_load_c;
  logic               lfsr_en_c;
  logic               hit_c;
  logic [DEST_W-1:0]  dest_c;
  logic [DATA_W-1:0]  data_c;
  logic [SEQ_W-1:0]   cnt_inc_c;

  // LFSR reseeds on an accepted start and advances only while waiting in GAP
  always_comb begin
    lfsr_load_c = (state == ST_IDLE) && I_START;
    lfsr_en_c   = (state == ST_GAP);
  end

  lfsr_step #(
    .RAND_W (RAND_W),
    .SEED   (SEED)
  ) u_lfsr (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .I_EN   (lfsr_en_c),
    .I_LOAD (lfsr_load_c),
    .O_DATA (rnd)
  );

  // Injection decision and candidate packet from the current random word
  always_comb begin
    hit_c  = rnd[7:0] < I_RATE;
    dest_c = rnd[RAND_W-1 -: DEST_W];
    if (dest_c == I_SRC_ID) begin
      dest_c = dest_c + DEST_W'(1);
    end
    data_c    = DATA_W'(rnd) | (DATA_W'(O_SENT_CNT) << (DATA_W - SEQ_W));
    cnt_inc_c = O_SENT_CNT + SEQ_W'(1);
  end

  // Controller FSM with registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      pkt_num    <= '0;
      stop_pend  <= 1'b0;
      O_VALID    <= 1'b0;
      O_DEST     <= '0;
      O_DATA     <= '0;
      O_BUSY     <= 1'b0;
      O_DONE     <= 1'b0;
      O_SENT_CNT <= '0;
    end else begin
      O_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_START) begin
            pkt_num    <= I_PKT_NUM;
            O_SENT_CNT <= '0;
            stop_pend  <= 1'b0;
            O_BUSY     <= 1'b1;
            if (I_PKT_NUM == '0) begin
              state  <= ST_DONE;
              O_DONE <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (I_STOP || stop_pend) begin
            state  <= ST_DONE;
            O_DONE <= 1'b1;
          end else if (hit_c) begin
            O_DEST  <= dest_c;
            O_DATA  <= data_c;
            O_VALID <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (I_READY) begin
            O_VALID    <= 1'b0;
            O_SENT_CNT <= cnt_inc_c;
            if ((cnt_inc_c == pkt_num) || stop_pend || I_STOP) begin
              state  <= ST_DONE;
              O_DONE <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end else if (I_STOP) begin
            stop_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          O_BUSY <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          O_VALID <= 1'b0;
          O_BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_traffic_ctrl.sv
// Randomized bench for rand_traffic_ctrl against a packet-list reference model.
module tb_rand_traffic_ctrl;

  localparam int unsigned RAND_W = 9;
  localparam int unsigned DEST_W = 2;
  localparam int unsigned DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              I_START, I_STOP, I_READY;
  logic [15:0]       I_PKT_NUM;
  logic [7:0]        I_RATE;
  logic [DEST_W-1:0] I_SRC_ID;
  logic              O_VALID, O_BUSY, O_DONE;
  logic [DEST_W-1:0] O_DEST;
  logic [DATA_W-1:0] O_DATA;
  logic [15:0]       O_SENT_CNT;

  int n_checks = 0;
  int n_errors = 0;

  rand_traffic_ctrl #(
    .RAND_W (RAND_W),
    .SEED   (9'h001),
    .DEST_W (DEST_W),
    .DATA_W (DATA_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .I_START    (I_START),
    .I_STOP     (I_STOP),
    .I_PKT_NUM  (I_PKT_NUM),
    .I_RATE     (I_RATE),
    .I_SRC_ID   (I_SRC_ID),
    .O_VALID    (O_VALID),
    .I_READY    (I_READY),
    .O_DEST     (O_DEST),
    .O_DATA     (O_DATA),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE),
    .O_SENT_CNT (O_SENT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Next random word: drop the msb, append (old msb xor old lsb) as the new lsb
  function automatic int unsigned lfsr_next(input int unsigned r);
    return ((r * 2) % 512) + (((r / 256) + r) % 2);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(O_VALID), 64'd0);
    chk({tag, "_busy"},  64'(O_BUSY),  64'd0);
    chk({tag, "_done"},  64'(O_DONE),  64'd0);
  endtask

  // One start..done run; the model lists each packet and how many GAP misses precede it
  task automatic run_burst(input int pkt_num, input int rate, input int src,
                           input int stop_pkt, input int stall_min, input int stall_max);
    int unsigned r;
    int unsigned misses;
    int unsigned e_dest;
    int unsigned e_data;
    int stall;
    int sent;
    r    = 1;
    sent = 0;
    I_PKT_NUM = 16'(pkt_num);
    I_RATE    = 8'(rate);
    I_SRC_ID  = DEST_W'(src);
    I_READY   = 1'b0;
    I_STOP    = 1'b0;
    I_START   = 1'b1;
    tick();
    I_START   = 1'b0;
    if (pkt_num == 0) begin
      chk("zero_done", 64'(O_DONE), 64'd1);
      chk("zero_busy", 64'(O_BUSY), 64'd1);
      chk("zero_valid", 64'(O_VALID), 64'd0);
      tick();
      chk_idle_outputs("zero_after");
      chk("zero_cnt", 64'(O_SENT_CNT), 64'd0);
      return;
    end
    for (int k = 0; k < pkt_num; k++) begin
      misses = 0;
      while ((r % 256) >= rate && misses < 4000) begin
        r = lfsr_next(r);
        misses++;
      end
      e_dest = r / (2 ** (RAND_W - DEST_W));
      if (e_dest == src) e_dest = (e_dest + 1) % (2 ** DEST_W);
      e_data = k * 65536 + r;
      r = lfsr_next(r);
      for (int g = 0; g <= int'(misses); g++) begin
        chk("gap_valid", 64'(O_VALID), 64'd0);
        chk("gap_busy", 64'(O_BUSY), 64'd1);
        chk("gap_cnt", 64'(O_SENT_CNT), 64'(sent));
        tick();
      end
      stall = $urandom_range(stall_max, stall_min);
      if (k == stop_pkt && stall == 0) stall = 1;
      for (int s = 0; s <= stall; s++) begin
        chk("send_valid", 64'(O_VALID), 64'd1);
        chk("send_dest", 64'(O_DEST), 64'(e_dest));
        chk("send_data", 64'(O_DATA), 64'(e_data));
        chk("send_cnt", 64'(O_SENT_CNT), 64'(sent));
        I_READY = (s == stall);
        I_STOP  = (k == stop_pkt) && (s == 0);
        I_START = ($urandom_range(3, 0) == 0);
        tick();
      end
      I_READY = 1'b0;
      I_STOP  = 1'b0;
      I_START = 1'b0;
      sent++;
      if (sent == pkt_num || k == stop_pkt) begin
        chk("done_pulse", 64'(O_DONE), 64'd1);
        chk("done_busy", 64'(O_BUSY), 64'd1);
        chk("done_valid", 64'(O_VALID), 64'd0);
        chk("done_cnt", 64'(O_SENT_CNT), 64'(sent));
        tick();
        chk_idle_outputs("after_done");
        chk("after_done_cnt", 64'(O_SENT_CNT), 64'(sent));
        return;
      end
    end
  endtask

  initial begin
    int pn, rt, sp;
    RST_N = 1'b0;
    I_START = 1'b0;
    I_STOP = 1'b0;
    I_READY = 1'b0;
    I_PKT_NUM = '0;
    I_RATE = '0;
    I_SRC_ID = '0;
    #1;
    chk_idle_outputs("reset");
    chk("reset_dest", 64'(O_DEST), 64'd0);
    chk("reset_data", 64'(O_DATA), 64'd0);
    chk("reset_cnt", 64'(O_SENT_CNT), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // Basic injection with the known first two packets
    run_burst(2, 8'hFF, 0, -1, 0, 0);
    chk("basic_last_dest", 64'(O_DEST), 64'd1);
    chk("basic_last_data", 64'(O_DATA), 64'h0001_0003);
    chk("basic_cnt", 64'(O_SENT_CNT), 64'd2);

    // Stop while idle has no effect
    I_STOP = 1'b1;
    tick();
    tick();
    I_STOP = 1'b0;
    chk_idle_outputs("idle_stop");
    chk("idle_stop_cnt", 64'(O_SENT_CNT), 64'd2);

    // Backpressure: five stall cycles per packet
    run_burst(2, 8'hFF, 0, -1, 5, 5);

    // Zero packet count
    run_burst(0, 8'hFF, 1, -1, 0, 0);

    // Rate zero never injects; stop ends the run
    I_PKT_NUM = 16'd5;
    I_RATE    = 8'd0;
    I_START   = 1'b1;
    tick();
    I_START   = 1'b0;
    for (int i = 0; i < 500; i++) begin
      chk("rate0_valid", 64'(O_VALID), 64'd0);
      chk("rate0_busy", 64'(O_BUSY), 64'd1);
      tick();
    end
    I_STOP = 1'b1;
    tick();
    I_STOP = 1'b0;
    chk("rate0_done", 64'(O_DONE), 64'd1);
    chk("rate0_cnt", 64'(O_SENT_CNT), 64'd0);
    tick();
    chk_idle_outputs("rate0_after");

    // Stop during SEND under backpressure
    run_burst(4, 8'hFF, 2, 1, 1, 3);

    // Reset while a packet is presented
    I_PKT_NUM = 16'd3;
    I_RATE    = 8'hFF;
    I_SRC_ID  = 2'd0;
    I_READY   = 1'b0;
    I_START   = 1'b1;
    tick();
    I_START   = 1'b0;
    tick();
    chk("prerst_valid", 64'(O_VALID), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_valid", 64'(O_VALID), 64'd0);
    chk("rst_async_busy", 64'(O_BUSY), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk_idle_outputs("post_rst");
    chk("post_rst_dest", 64'(O_DEST), 64'd0);
    chk("post_rst_data", 64'(O_DATA), 64'd0);
    chk("post_rst_cnt", 64'(O_SENT_CNT), 64'd0);
    run_burst(2, 8'hFF, 0, -1, 0, 2);

    // Randomized runs
    for (int it = 0; it < 25; it++) begin
      pn = $urandom_range(6, 1);
      rt = ($urandom_range(3, 0) == 0) ? 8'hFF : $urandom_range(8'hFF, 8'h40);
      sp = ($urandom_range(2, 0) == 0) ? $urandom_range(pn - 1, 0) : -1;
      run_burst(pn, rt, $urandom_range(3, 0), sp, 0, 3);
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
